// File: rtl/px_hdl_blend_feeder_if.sv
// Stream bundle around the blend feeder: source and destination pixel
// inputs plus the registered operand stream toward the blend unit.
// The master modport is the feeder itself, the slave modport is its environment.
interface px_hdl_blend_feeder_if;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic [31:0] dst_data;
  logic        dst_valid;
  logic        dst_ready;
  logic [7:0]  a1, r1, g1, b1;
  logic [7:0]  a2, r2, g2, b2;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    input  src_data, src_valid, dst_data, dst_valid, out_ready,
    output src_ready, dst_ready, a1, r1, g1, b1, a2, r2, g2, b2,
    output out_valid, out_last
  );

  modport slave (
    output src_data, src_valid, dst_data, dst_valid, out_ready,
    input  src_ready, dst_ready, a1, r1, g1, b1, a2, r2, g2, b2,
    input  out_valid, out_last
  );
endinterface

// File: rtl/px_hdl_blend_feeder.sv
// Joins source and destination pixel streams, scales source alpha by the
// job opacity and presents registered operands to the alpha-blend unit.
// Two-stage pipeline, one pixel per clock, jobs bracketed by start/busy/done.
module px_hdl_blend_feeder #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] pixel_count,
  input  logic [7:0]       opacity,
  output logic             busy,
  output logic             done,
  px_hdl_blend_feeder_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] count_reg;
  logic [7:0]       opacity_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             s1_valid_reg;
  logic             s1_last_reg;
  logic [23:0]      s1_rgb_reg;
  logic [31:0]      s1_dst_reg;
  logic [15:0]      s1_prod_reg;

  logic             s2_valid_reg;
  logic             s2_last_reg;
  logic [31:0]      s2_src_reg;
  logic [31:0]      s2_dst_reg;

  logic             s2_free;
  logic             s1_adv;
  logic             s1_free;
  logic             can_take;
  logic             join_fire;
  logic             last_fire;
  logic [15:0]      prod_next;

  // Stage 2 can take new data when empty or being drained this cycle
  assign s2_free   = !s2_valid_reg || bus.out_ready;
  assign s1_adv    = s1_valid_reg && s2_free;
  assign s1_free   = !s1_valid_reg || s2_free;

  // A side is ready only when the other side is valid, so both streams
  // always complete their handshakes together
  assign can_take      = (state_reg == ST_RUN) && (cnt_reg < count_reg) && s1_free;
  assign bus.src_ready = can_take && bus.dst_valid;
  assign bus.dst_ready = can_take && bus.src_valid;
  assign join_fire     = can_take && bus.src_valid && bus.dst_valid;
  assign last_fire     = s2_valid_reg && bus.out_ready && s2_last_reg;

  // 8x9 multiply; max 255*256 = 65280 fits in 16 bits
  assign prod_next = {8'd0, bus.src_data[31:24]} * ({8'd0, opacity_reg} + 16'd1);

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign bus.out_valid = s2_valid_reg;
  assign bus.out_last  = s2_last_reg;
  assign bus.a1        = s2_src_reg[31:24];
  assign bus.r1        = s2_src_reg[23:16];
  assign bus.g1        = s2_src_reg[15:8];
  assign bus.b1        = s2_src_reg[7:0];
  assign bus.a2        = s2_dst_reg[31:24];
  assign bus.r2        = s2_dst_reg[23:16];
  assign bus.g2        = s2_dst_reg[15:8];
  assign bus.b2        = s2_dst_reg[7:0];

  // Job control: config latch, input counter, busy/done sequencing.
  // A zero-count job passes through DONE with busy high first and raises
  // done one cycle later; a normal job raises done as DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      count_reg   <= '0;
      opacity_reg <= 8'd0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            count_reg   <= pixel_count;
            opacity_reg <= opacity;
            cnt_reg     <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= (pixel_count == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (join_fire) cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == count_reg) state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (last_fire) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= (count_reg == '0);
        end
      endcase
    end
  end

  // Stage 1: capture the joined pair, scaled alpha product and last tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_rgb_reg   <= 24'd0;
      s1_dst_reg   <= 32'd0;
      s1_prod_reg  <= 16'd0;
    end else if (join_fire) begin
      s1_valid_reg <= 1'b1;
      s1_last_reg  <= (cnt_reg == count_reg - CNT_W'(1));
      s1_rgb_reg   <= bus.src_data[23:0];
      s1_dst_reg   <= bus.dst_data;
      s1_prod_reg  <= prod_next;
    end else if (s1_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Stage 2: operand registers, held stable while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_last_reg  <= 1'b0;
      s2_src_reg   <= 32'd0;
      s2_dst_reg   <= 32'd0;
    end else if (s1_adv) begin
      s2_valid_reg <= 1'b1;
      s2_last_reg  <= s1_last_reg;
      s2_src_reg   <= {s1_prod_reg[15:8], s1_rgb_reg};
      s2_dst_reg   <= s1_dst_reg;
    end else if (bus.out_ready) begin
      s2_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_px_hdl_blend_feeder.sv
// Directed bench for the blend feeder: single pixels, opacity scaling,
// zero-count job, backpressure, skewed arrival and reset mid-job.
module tb_px_hdl_blend_feeder;
  localparam int CNT_W = 24;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] pixel_count;
  logic [7:0]       opacity;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;
  int r_idx;
  logic r_hs;

  px_hdl_blend_feeder_if bus ();

  px_hdl_blend_feeder #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pixel_count (pixel_count),
    .opacity     (opacity),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] src_px(input int i);
    return {8'(240 + i), 8'(3 * i), 8'(5 * i), 8'(7 * i)};
  endfunction

  function automatic logic [31:0] dst_px(input int i);
    return {8'(128 + i), 8'(i + 9), 8'(192 - i), 8'(11 * i)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic one_pixel_job(input logic [7:0] op, input logic [31:0] s,
                               input logic [31:0] d, input logic [31:0] e1);
    pixel_count   = CNT_W'(1);
    opacity       = op;
    start         = 1'b1;
    bus.src_data  = s;
    bus.dst_data  = d;
    bus.src_valid = 1'b1;
    bus.dst_valid = 1'b1;
    #1;
    chk("px_idle_ready", bus.src_ready, 1'b0);
    tick;
    start = 1'b0;
    #1;
    chk("px_busy", busy, 1'b1);
    chk("px_src_ready", bus.src_ready, 1'b1);
    chk("px_dst_ready", bus.dst_ready, 1'b1);
    tick;
    chk("px_no_second_take", bus.src_ready, 1'b0);
    bus.src_valid = 1'b0;
    bus.dst_valid = 1'b0;
    tick;
    chk("px_out_valid", bus.out_valid, 1'b1);
    chk("px_word1", {bus.a1, bus.r1, bus.g1, bus.b1}, e1);
    chk("px_word2", {bus.a2, bus.r2, bus.g2, bus.b2}, d);
    chk("px_last", bus.out_last, 1'b1);
    chk("px_done_early", done, 1'b0);
    tick;
    chk("px_done", done, 1'b1);
    chk("px_busy_at_done", busy, 1'b1);
    chk("px_out_clear", bus.out_valid, 1'b0);
    tick;
    chk("px_done_pulse", done, 1'b0);
    chk("px_busy_end", busy, 1'b0);
  endtask

  // Streams n pixels at opacity 255 with optional output stall; pokes a
  // start with different config mid-job, which must be ignored.
  task automatic stream_job(input int n, input int stall_at, input int stall_len);
    int in_idx;
    int out_idx;
    int done_cnt;
    logic hs;
    in_idx   = 0;
    out_idx  = 0;
    done_cnt = 0;
    pixel_count   = CNT_W'(n);
    opacity       = 8'hFF;
    start         = 1'b1;
    bus.src_data  = src_px(0);
    bus.dst_data  = dst_px(0);
    bus.src_valid = 1'b1;
    bus.dst_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 1) begin
        pixel_count = CNT_W'(3);
        opacity     = 8'h00;
      end
      if (cyc == 2) start = 1'b0;
      bus.out_ready = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      if (cyc == 0) chk("st_idle_ready", bus.src_ready, 1'b0);
      if (cyc == 1) chk("st_busy", busy, 1'b1);
      if (done) done_cnt++;
      if (stall_len > 0 && cyc > stall_at && cyc < stall_at + stall_len)
        chk("st_stall_ready", bus.src_ready, 1'b0);
      if (bus.out_valid && out_idx < n) begin
        chk("st_word1", {bus.a1, bus.r1, bus.g1, bus.b1}, src_px(out_idx));
        chk("st_word2", {bus.a2, bus.r2, bus.g2, bus.b2}, dst_px(out_idx));
        chk("st_last", bus.out_last, out_idx == n - 1);
        if (bus.out_ready) out_idx++;
      end else if (bus.out_valid) begin
        chk("st_extra_output", bus.out_valid, 1'b0);
      end
      hs = bus.src_ready && bus.dst_ready;
      tick;
      if (hs) begin
        in_idx++;
        bus.src_data = src_px(in_idx);
        bus.dst_data = dst_px(in_idx);
      end
    end
    chk("st_in_count", in_idx, n);
    chk("st_out_count", out_idx, n);
    chk("st_done_count", done_cnt, 1);
    chk("st_busy_end", busy, 1'b0);
    bus.src_valid = 1'b0;
    bus.dst_valid = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    pixel_count   = '0;
    opacity       = 8'd0;
    bus.src_data  = 32'd0;
    bus.dst_data  = 32'd0;
    bus.src_valid = 1'b0;
    bus.dst_valid = 1'b0;
    bus.out_ready = 1'b1;

    // reset state
    tick; tick; tick;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_src_ready", bus.src_ready, 1'b0);
    chk("rst_dst_ready", bus.dst_ready, 1'b0);
    chk("rst_word1", {bus.a1, bus.r1, bus.g1, bus.b1}, 32'd0);
    chk("rst_word2", {bus.a2, bus.r2, bus.g2, bus.b2}, 32'd0);
    rst_n = 1'b1;
    tick;

    // single pixel and opacity scaling
    one_pixel_job(8'hFF, 32'h80FF0000, 32'hFF0000FF, 32'h80FF0000);
    one_pixel_job(8'h7F, 32'hFF123456, 32'h11223344, 32'h7F123456);
    one_pixel_job(8'h00, 32'hFFABCDEF, 32'h5A6B7C8D, 32'h00ABCDEF);

    // zero-count job, valids held high to expose any ready
    pixel_count   = '0;
    opacity       = 8'h55;
    start         = 1'b1;
    bus.src_valid = 1'b1;
    bus.dst_valid = 1'b1;
    #1;
    chk("zero_c0_ready", bus.src_ready | bus.dst_ready, 1'b0);
    tick;
    start = 1'b0;
    #1;
    chk("zero_c1_busy", busy, 1'b1);
    chk("zero_c1_done", done, 1'b0);
    chk("zero_c1_ready", bus.src_ready | bus.dst_ready, 1'b0);
    tick;
    chk("zero_c2_done", done, 1'b1);
    chk("zero_c2_busy", busy, 1'b0);
    chk("zero_c2_ready", bus.src_ready | bus.dst_ready, 1'b0);
    tick;
    chk("zero_c3_done", done, 1'b0);
    bus.src_valid = 1'b0;
    bus.dst_valid = 1'b0;
    tick;

    // backpressure: 8 pixels, 5-cycle output stall
    stream_job(8, 6, 5);
    tick;

    // skewed arrival: src first, dst three cycles later
    pixel_count   = CNT_W'(1);
    opacity       = 8'hFF;
    start         = 1'b1;
    bus.src_data  = 32'h40302010;
    bus.dst_data  = 32'h0A0B0C0D;
    bus.src_valid = 1'b1;
    bus.dst_valid = 1'b0;
    tick;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("skew_src_ready", bus.src_ready, 1'b0);
      chk("skew_dst_ready", bus.dst_ready, 1'b1);
      tick;
    end
    bus.dst_valid = 1'b1;
    #1;
    chk("skew_join_src", bus.src_ready, 1'b1);
    chk("skew_join_dst", bus.dst_ready, 1'b1);
    tick;
    bus.src_valid = 1'b0;
    bus.dst_valid = 1'b0;
    tick;
    chk("skew_out_valid", bus.out_valid, 1'b1);
    chk("skew_word1", {bus.a1, bus.r1, bus.g1, bus.b1}, 32'h40302010);
    chk("skew_word2", {bus.a2, bus.r2, bus.g2, bus.b2}, 32'h0A0B0C0D);
    chk("skew_last", bus.out_last, 1'b1);
    tick;
    chk("skew_done", done, 1'b1);
    tick;

    // reset after 3 of 10 pixels
    pixel_count   = CNT_W'(10);
    opacity       = 8'hFF;
    start         = 1'b1;
    bus.src_data  = src_px(0);
    bus.dst_data  = dst_px(0);
    bus.src_valid = 1'b1;
    bus.dst_valid = 1'b1;
    r_idx = 0;
    for (int cyc = 0; cyc < 12 && r_idx < 3; cyc++) begin
      if (cyc == 1) start = 1'b0;
      #1;
      r_hs = bus.src_ready && bus.dst_ready;
      tick;
      if (r_hs) begin
        r_idx++;
        bus.src_data = src_px(r_idx);
        bus.dst_data = dst_px(r_idx);
      end
    end
    chk("mid_pre_joins", r_idx, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", bus.out_valid, 1'b0);
    chk("mid_word1", {bus.a1, bus.r1, bus.g1, bus.b1}, 32'd0);
    chk("mid_word2", {bus.a2, bus.r2, bus.g2, bus.b2}, 32'd0);
    chk("mid_last", bus.out_last, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_done", done, 1'b0);
    chk("mid_ready", bus.src_ready | bus.dst_ready, 1'b0);
    bus.src_valid = 1'b0;
    bus.dst_valid = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      chk("mid_no_done", done, 1'b0);
      chk("mid_idle_busy", busy, 1'b0);
    end
    stream_job(2, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
